// File: rtl/bus_xfer_pkg.sv
// rtl/bus_xfer_pkg.sv - shared state codes, default widths and enable decode for bus_xfer_sched
package bus_xfer_pkg;
    localparam int NREQ_DEF   = 4;
    localparam int NREG_DEF   = 8;
    localparam int IDXW_DEF   = 3;
    localparam int SETTLE_DEF = 1;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_DRIVE = 3'd1;
    localparam state_t S_LATCH = 3'd2;
    localparam state_t S_CLEAR = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Active-low one-hot; callers truncate to their register count.
    function automatic logic [31:0] idx_dec_n(input logic [4:0] idx);
        logic [31:0] v;
        v = '1;
        v[idx] = 1'b0;
        return v;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant scan starting at an external pointer
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + 32'(k)) % 32'(N));
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_xfer_sched.sv
// rtl/bus_xfer_sched.sv - round-robin sequencer driving oe_n/en_n/clr_n of a shared tristate register bus
module bus_xfer_sched
    import bus_xfer_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int IDXW   = IDXW_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_clr,
    input  logic [NREQ*IDXW-1:0] req_src,
    input  logic [NREQ*IDXW-1:0] req_dst,
    output logic [NREQ-1:0]      accept,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy,
    output logic [NREG-1:0]      oe_n,
    output logic [NREG-1:0]      en_n,
    output logic [NREG-1:0]      clr_n
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_win;
    logic [IDXW-1:0]   src_q, src_d, dst_q, dst_d;
    logic [IDXW-1:0]   win_src, win_dst;
    logic              win_clr, bad_idx, err_d;
    logic [NREQ-1:0]   owner_q, owner_d, grant;
    logic [3:0]        cnt_q, cnt_d;
    logic [NREG-1:0]   src_dec, dst_dec;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (grant)
    );

    assign accept = (state_q == S_IDLE) ? grant : '0;
    assign busy   = (state_q != S_IDLE);

    always_comb begin
        win_src = '0;
        win_dst = '0;
        win_clr = 1'b0;
        ptr_win = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_src = req_src[i*IDXW +: IDXW];
                win_dst = req_dst[i*IDXW +: IDXW];
                win_clr = req_clr[i];
                ptr_win = PW'((i + 1) % NREQ);
            end
        end
    end

    // A clear ignores its source field, so only the destination is range-checked.
    assign bad_idx = (32'(win_dst) >= NREG) || (!win_clr && (32'(win_src) >= NREG));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        dst_d   = dst_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    ptr_d   = ptr_win;
                    src_d   = win_src;
                    dst_d   = win_dst;
                    owner_d = grant;
                    cnt_d   = 4'(SETTLE - 1);
                    if (bad_idx) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (win_clr) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == 4'd0) state_d = S_LATCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_LATCH, S_CLEAR: state_d = S_DONE;
            default:          state_d = S_IDLE;
        endcase
    end

    // Enables are registered from the next state so each pin changes only at a clock edge.
    assign src_dec = NREG'(idx_dec_n(5'(src_d)));
    assign dst_dec = NREG'(idx_dec_n(5'(dst_d)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            oe_n    <= '1;
            en_n    <= '1;
            clr_n   <= '1;
            done    <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            oe_n    <= (state_d == S_DRIVE || state_d == S_LATCH) ? src_dec : '1;
            en_n    <= (state_d == S_LATCH) ? dst_dec : '1;
            clr_n   <= (state_d == S_CLEAR) ? dst_dec : '1;
            done    <= (state_d == S_DONE) ? owner_d : '0;
            err     <= err_d;
        end
    end
endmodule

// File: tb/tb_bus_xfer_sched.sv
// tb/tb_bus_xfer_sched.sv - self-checking bench for bus_xfer_sched
module tb_bus_xfer_sched;
    localparam int SETTLE_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    logic mon_on = 1'b0;

    logic        a_rst, a_err, a_busy;
    logic [3:0]  a_req, a_req_clr, a_accept, a_done;
    logic [11:0] a_req_src, a_req_dst;
    logic [7:0]  a_oe_n, a_en_n, a_clr_n;

    logic        b_rst, b_err, b_busy;
    logic [3:0]  b_req, b_req_clr, b_accept, b_done;
    logic [11:0] b_req_src, b_req_dst;
    logic [5:0]  b_oe_n, b_en_n, b_clr_n;

    bus_xfer_sched #(.NREQ(4), .NREG(8), .IDXW(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst(a_rst), .req(a_req), .req_clr(a_req_clr),
        .req_src(a_req_src), .req_dst(a_req_dst), .accept(a_accept),
        .done(a_done), .err(a_err), .busy(a_busy),
        .oe_n(a_oe_n), .en_n(a_en_n), .clr_n(a_clr_n)
    );

    bus_xfer_sched #(.NREQ(4), .NREG(6), .IDXW(3), .SETTLE(SETTLE_B)) dut_b (
        .clk(clk), .rst(b_rst), .req(b_req), .req_clr(b_req_clr),
        .req_src(b_req_src), .req_dst(b_req_dst), .accept(b_accept),
        .done(b_done), .err(b_err), .busy(b_busy),
        .oe_n(b_oe_n), .en_n(b_en_n), .clr_n(b_clr_n)
    );

    typedef struct {
        logic [3:0] who;
        logic       err;
        int         due;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd_a(input int i, input logic c, input logic [2:0] s, input logic [2:0] d);
        a_req_clr[i]       = c;
        a_req_src[i*3 +: 3] = s;
        a_req_dst[i*3 +: 3] = d;
    endtask

    task automatic set_cmd_b(input int i, input logic c, input logic [2:0] s, input logic [2:0] d);
        b_req_clr[i]       = c;
        b_req_src[i*3 +: 3] = s;
        b_req_dst[i*3 +: 3] = d;
    endtask

    task automatic wait_idle_a();
        int c = 0;
        while (a_busy && c < 50) begin
            tick();
            c++;
        end
        check("idle_timeout", 32'(c < 50), 1);
    endtask

    task automatic rr_expect(input logic [3:0] r, input int n, input logic [19:0] seq);
        int got_n = 0;
        a_req = r;
        for (int c = 0; c < 80 && got_n < n; c++) begin
            @(negedge clk);
            if (a_accept != 4'b0) begin
                check("rr_order", 32'(a_accept), 32'(seq[4*got_n +: 4]));
                got_n++;
            end
            tick();
            if (got_n == n) a_req = 4'b0;
        end
        a_req = 4'b0;
        check("rr_count", got_n, n);
        wait_idle_a();
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("a_inv_oe",  32'($countones(~a_oe_n) <= 1), 1);
            check("a_inv_en",  32'($countones(~a_en_n) <= 1), 1);
            check("a_inv_clr", 32'($countones(~a_clr_n) <= 1), 1);
            check("a_inv_oe_clr", 32'((a_oe_n != '1) && (a_clr_n != '1)), 0);
            check("b_inv_oe",  32'($countones(~b_oe_n) <= 1), 1);
            check("b_inv_en",  32'($countones(~b_en_n) <= 1), 1);
            check("b_inv_clr", 32'($countones(~b_clr_n) <= 1), 1);
            check("b_inv_oe_clr", 32'((b_oe_n != '1) && (b_clr_n != '1)), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_acc, exp_done, acc_last;
        logic       exp_err, bad;
        int         mptr, next_free, cyc, lat, w;

        a_rst = 1'b1; b_rst = 1'b1;
        a_req = '0; a_req_clr = '0; a_req_src = '0; a_req_dst = '0;
        b_req = '0; b_req_clr = '0; b_req_src = '0; b_req_dst = '0;
        repeat (2) tick();
        a_rst = 1'b0; b_rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("rst_oe", 32'(a_oe_n), 'hFF);
        check("rst_en", 32'(a_en_n), 'hFF);
        check("rst_clr", 32'(a_clr_n), 'hFF);
        check("rst_done_err_busy", 32'({a_done, a_err, a_busy}), 0);
        check("rst_b_enables", 32'({b_oe_n, b_en_n, b_clr_n}), 'h3FFFF);
        tick();

        // transfer 2 -> 5
        set_cmd_a(0, 1'b0, 3'd2, 3'd5);
        a_req = 4'b0001;
        @(negedge clk); check("xfer_accept", 32'(a_accept), 'h1);
        tick(); a_req = '0;
        @(negedge clk);
        check("xfer_drive_oe", 32'(a_oe_n), 'hFB);
        check("xfer_drive_en", 32'(a_en_n), 'hFF);
        check("xfer_busy", 32'(a_busy), 1);
        tick(); @(negedge clk);
        check("xfer_latch_oe", 32'(a_oe_n), 'hFB);
        check("xfer_latch_en", 32'(a_en_n), 'hDF);
        tick(); @(negedge clk);
        check("xfer_turn_enables", 32'({a_oe_n, a_en_n}), 'hFFFF);
        check("xfer_done", 32'(a_done), 'h1);
        check("xfer_err", 32'(a_err), 0);
        tick(); @(negedge clk);
        check("xfer_idle", 32'({a_done, a_busy}), 0);
        tick();

        // clear register 7 from requester 1
        set_cmd_a(1, 1'b1, 3'd0, 3'd7);
        a_req = 4'b0010;
        @(negedge clk); check("clr_accept", 32'(a_accept), 'h2);
        tick(); a_req = '0;
        @(negedge clk);
        check("clr_pulse", 32'(a_clr_n), 'h7F);
        check("clr_no_oe_en", 32'({a_oe_n, a_en_n}), 'hFFFF);
        check("clr_done_early", 32'(a_done), 0);
        tick(); @(negedge clk);
        check("clr_release", 32'(a_clr_n), 'hFF);
        check("clr_done", 32'(a_done), 'h2);
        tick();

        // reset while in LATCH
        set_cmd_a(2, 1'b0, 3'd1, 3'd3);
        a_req = 4'b0100;
        @(negedge clk); check("rm_accept", 32'(a_accept), 'h4);
        tick(); a_req = '0;
        tick(); a_rst = 1'b1;
        @(negedge clk); check("rm_latch_en", 32'(a_en_n), 'hF7);
        tick(); a_rst = 1'b0;
        @(negedge clk);
        check("rm_enables", 32'({a_oe_n, a_en_n, a_clr_n}), 'hFFFFFF);
        check("rm_busy", 32'(a_busy), 0);
        for (int c = 0; c < 3; c++) begin
            tick(); @(negedge clk);
            check("rm_no_done", 32'(a_done), 0);
        end
        tick();

        // round robin, src==dst transfers; first grant shows ptr back at 0
        for (int i = 0; i < 4; i++) set_cmd_a(i, 1'b0, 3'(i), 3'(i));
        rr_expect(4'b1111, 5, 20'h18421);
        rr_expect(4'b0010, 1, 20'h00002);
        rr_expect(4'b1010, 2, 20'h00028);

        // self reload of register 4
        set_cmd_a(3, 1'b0, 3'd4, 3'd4);
        a_req = 4'b1000;
        @(negedge clk); check("self_accept", 32'(a_accept), 'h8);
        tick(); a_req = '0;
        tick(); @(negedge clk);
        check("self_oe", 32'(a_oe_n), 'hEF);
        check("self_en", 32'(a_en_n), 'hEF);
        tick(); @(negedge clk);
        check("self_done", 32'(a_done), 'h8);
        tick();

        // NREG=6 instance: destination 6 is out of range
        set_cmd_b(0, 1'b0, 3'd1, 3'd6);
        b_req = 4'b0001;
        @(negedge clk);
        check("bad_accept", 32'(b_accept), 'h1);
        check("bad_enables_acc", 32'({b_oe_n, b_en_n, b_clr_n}), 'h3FFFF);
        tick(); b_req = '0;
        @(negedge clk);
        check("bad_done", 32'(b_done), 'h1);
        check("bad_err", 32'(b_err), 1);
        check("bad_enables", 32'({b_oe_n, b_en_n, b_clr_n}), 'h3FFFF);
        tick(); @(negedge clk);
        check("bad_after", 32'({b_done, b_err, b_busy}), 0);
        tick();

        // randomized back-to-back traffic against a scoreboard
        b_rst = 1'b1; tick(); b_rst = 1'b0;
        mptr = 0; next_free = 0; cyc = 0; acc_last = '0;
        for (int c = 0; c < 700; c++) begin
            tick(); cyc++;
            for (int i = 0; i < 4; i++) begin
                if (acc_last[i]) b_req[i] = 1'b0;
                if (c < 600 && !b_req[i] && $urandom_range(0, 2) == 0) begin
                    set_cmd_b(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                    b_req[i] = 1'b1;
                end
            end
            @(negedge clk);
            exp_done = '0; exp_err = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_done = sb[0].who;
                exp_err  = sb[0].err;
                void'(sb.pop_front());
            end
            check("rnd_done", 32'(b_done), 32'(exp_done));
            check("rnd_err", 32'(b_err), 32'(exp_err));
            exp_acc = '0;
            if (cyc >= next_free) begin
                w = -1;
                for (int k = 3; k >= 0; k--) if (b_req[(mptr + k) % 4]) w = (mptr + k) % 4;
                if (w >= 0) begin
                    exp_acc[w] = 1'b1;
                    bad = (32'(b_req_dst[w*3 +: 3]) >= 6) ||
                          (!b_req_clr[w] && (32'(b_req_src[w*3 +: 3]) >= 6));
                    lat = bad ? 1 : (b_req_clr[w] ? 2 : SETTLE_B + 2);
                    sb.push_back('{exp_acc, bad, cyc + lat});
                    next_free = cyc + lat + 1;
                    mptr = (w + 1) % 4;
                end
            end
            check("rnd_accept", 32'(b_accept), 32'(exp_acc));
            acc_last = exp_acc;
        end
        check("rnd_outstanding", sb.size(), 0);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
